// File: rtl/ram_dp_be.sv
`default_nettype none
// ============================================================================
// ram_dp_be : true dual-port synchronous RAM with byte-masked writes,
//             per-port read-valid strobes and a write-write collision flag.
// Revision  : 1.0
// ============================================================================
module ram_dp_be #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 11,
  parameter int WRITE_FIRST = 1,
  parameter int OUT_REG     = 0
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                ENA,
  input  logic [DATA_W/8-1:0] WEA,
  input  logic [ADDR_W-1:0]   ADDRA,
  input  logic [DATA_W-1:0]   DINA,
  output logic [DATA_W-1:0]   DOUTA,
  output logic                DVALA,
  input  logic                ENB,
  input  logic [DATA_W/8-1:0] WEB,
  input  logic [ADDR_W-1:0]   ADDRB,
  input  logic [DATA_W-1:0]   DINB,
  output logic [DATA_W-1:0]   DOUTB,
  output logic                DVALB,
  output logic                COLL
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [NB-1:0]     wea_gated;
  logic [NB-1:0]     web_gated;
  logic [DATA_W-1:0] old_a;
  logic [DATA_W-1:0] old_b;
  logic [DATA_W-1:0] merged_a;
  logic [DATA_W-1:0] merged_b;
  logic [DATA_W-1:0] rdata_a_d;
  logic [DATA_W-1:0] rdata_b_d;
  logic              coll_d;

  logic [DATA_W-1:0] s1_data_a_q;
  logic [DATA_W-1:0] s1_data_b_q;
  logic              s1_val_a_q;
  logic              s1_val_b_q;
  logic              coll_q;

  assign wea_gated = (ENA && !RST) ? WEA : '0;
  assign web_gated = (ENB && !RST) ? WEB : '0;

  // Port A is applied last so it owns every byte both ports write together.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < NB; i++) begin
      if (web_gated[i]) mem_q[ADDRB][8*i +: 8] <= DINB[8*i +: 8];
      if (wea_gated[i]) mem_q[ADDRA][8*i +: 8] <= DINA[8*i +: 8];
    end
  end

  assign old_a = mem_q[ADDRA];
  assign old_b = mem_q[ADDRB];

  always_comb begin
    merged_a = old_a;
    merged_b = old_b;
    for (int i = 0; i < NB; i++) begin
      if (WEA[i]) merged_a[8*i +: 8] = DINA[8*i +: 8];
      if (WEB[i]) merged_b[8*i +: 8] = DINB[8*i +: 8];
    end
  end

  // Only the own-port write can be forwarded; the other port always sees old data.
  assign rdata_a_d = (WRITE_FIRST != 0) ? merged_a : old_a;
  assign rdata_b_d = (WRITE_FIRST != 0) ? merged_b : old_b;

  assign coll_d = ENA && ENB && (ADDRA == ADDRB) && (|(WEA & WEB));

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_data_a_q <= '0;
      s1_data_b_q <= '0;
      s1_val_a_q  <= 1'b0;
      s1_val_b_q  <= 1'b0;
      coll_q      <= 1'b0;
    end else begin
      s1_val_a_q <= ENA;
      s1_val_b_q <= ENB;
      coll_q     <= coll_d;
      if (ENA) s1_data_a_q <= rdata_a_d;
      if (ENB) s1_data_b_q <= rdata_b_d;
    end
  end

  assign COLL = coll_q;

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_W-1:0] s2_data_a_q;
      logic [DATA_W-1:0] s2_data_b_q;
      logic              s2_val_a_q;
      logic              s2_val_b_q;

      always_ff @(posedge CLK) begin
        if (RST) begin
          s2_data_a_q <= '0;
          s2_data_b_q <= '0;
          s2_val_a_q  <= 1'b0;
          s2_val_b_q  <= 1'b0;
        end else begin
          s2_val_a_q <= s1_val_a_q;
          s2_val_b_q <= s1_val_b_q;
          if (s1_val_a_q) s2_data_a_q <= s1_data_a_q;
          if (s1_val_b_q) s2_data_b_q <= s1_data_b_q;
        end
      end

      assign DOUTA = s2_data_a_q;
      assign DOUTB = s2_data_b_q;
      assign DVALA = s2_val_a_q;
      assign DVALB = s2_val_b_q;
    end else begin : g_no_out_reg
      assign DOUTA = s1_data_a_q;
      assign DOUTB = s1_data_b_q;
      assign DVALA = s1_val_a_q;
      assign DVALB = s1_val_b_q;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_ram_dp_be.sv
`default_nettype none
// ============================================================================
// tb_ram_dp_be : directed bench driving two ram_dp_be instances in parallel,
//                latency-1/write-first and latency-2/read-first.
// Revision     : 1.0
// ============================================================================
module tb_ram_dp_be;

  logic        clk;
  logic        rst;
  logic        ena, enb;
  logic [3:0]  wea, web;
  logic [10:0] addra, addrb;
  logic [31:0] dina, dinb;

  logic [31:0] douta0, doutb0, douta1, doutb1;
  logic        dvala0, dvalb0, coll0, dvala1, dvalb1, coll1;

  int n_checks = 0;
  int n_fail   = 0;

  ram_dp_be #(.DATA_W(32), .ADDR_W(11), .WRITE_FIRST(1), .OUT_REG(0)) dut0 (
    .CLK(clk), .RST(rst),
    .ENA(ena), .WEA(wea), .ADDRA(addra), .DINA(dina), .DOUTA(douta0), .DVALA(dvala0),
    .ENB(enb), .WEB(web), .ADDRB(addrb), .DINB(dinb), .DOUTB(doutb0), .DVALB(dvalb0),
    .COLL(coll0)
  );

  ram_dp_be #(.DATA_W(32), .ADDR_W(11), .WRITE_FIRST(0), .OUT_REG(1)) dut1 (
    .CLK(clk), .RST(rst),
    .ENA(ena), .WEA(wea), .ADDRA(addra), .DINA(dina), .DOUTA(douta1), .DVALA(dvala1),
    .ENB(enb), .WEB(web), .ADDRB(addrb), .DINB(dinb), .DOUTB(doutb1), .DVALB(dvalb1),
    .COLL(coll1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    ena = 1'b0; wea = 4'h0; enb = 1'b0; web = 4'h0;
  endtask

  // Advance one rising edge and leave time 1 ns past it for sampling/driving.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_a(input logic [10:0] a, input logic [31:0] d, input logic [3:0] m);
    ena = 1'b1; wea = m; addra = a; dina = d;
    cyc();
    idle();
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(); addra = '0; addrb = '0; dina = '0; dinb = '0;
    cyc(); cyc();
    n_checks++; if (douta0 !== 32'h0) begin n_fail++; $display("FAIL rst_douta0 got %h exp %h", douta0, 32'h0); end
    n_checks++; if (dvala0 !== 1'b0) begin n_fail++; $display("FAIL rst_dvala0 got %b exp 0", dvala0); end
    n_checks++; if (doutb0 !== 32'h0) begin n_fail++; $display("FAIL rst_doutb0 got %h exp %h", doutb0, 32'h0); end
    n_checks++; if (dvalb0 !== 1'b0) begin n_fail++; $display("FAIL rst_dvalb0 got %b exp 0", dvalb0); end
    n_checks++; if (coll0 !== 1'b0) begin n_fail++; $display("FAIL rst_coll0 got %b exp 0", coll0); end
    n_checks++; if (douta1 !== 32'h0) begin n_fail++; $display("FAIL rst_douta1 got %h exp %h", douta1, 32'h0); end
    n_checks++; if (dvala1 !== 1'b0) begin n_fail++; $display("FAIL rst_dvala1 got %b exp 0", dvala1); end
    rst = 1'b0;
    wr_a(11'd100, 32'h0000_0001, 4'hF);
    cyc();
    // A write presented during reset must be dropped.
    rst = 1'b1; ena = 1'b1; wea = 4'hF; addra = 11'd100; dina = 32'hFFFF_FFFF;
    cyc();
    n_checks++; if (dvala0 !== 1'b0) begin n_fail++; $display("FAIL rst_wr_dvala0 got %b exp 0", dvala0); end
    rst = 1'b0; idle();
    ena = 1'b1; addra = 11'd100;
    cyc(); idle();
    n_checks++; if (douta0 !== 32'h0000_0001) begin n_fail++; $display("FAIL rst_wr_ignored got %h exp %h", douta0, 32'h0000_0001); end
    cyc(); cyc();
  endtask

  task automatic test_latency();
    wr_a(11'd5, 32'h1122_3344, 4'hF);
    cyc();
    rst = 1'b1; cyc(); rst = 1'b0; cyc();
    ena = 1'b1; wea = 4'h0; addra = 11'd5;
    cyc(); idle();
    n_checks++; if (douta0 !== 32'h1122_3344) begin n_fail++; $display("FAIL lat0_douta got %h exp %h", douta0, 32'h1122_3344); end
    n_checks++; if (dvala0 !== 1'b1) begin n_fail++; $display("FAIL lat0_dvala got %b exp 1", dvala0); end
    n_checks++; if (dvala1 !== 1'b0) begin n_fail++; $display("FAIL lat1_dvala_early got %b exp 0", dvala1); end
    cyc();
    n_checks++; if (dvala0 !== 1'b0) begin n_fail++; $display("FAIL lat0_dvala_pulse got %b exp 0", dvala0); end
    n_checks++; if (douta0 !== 32'h1122_3344) begin n_fail++; $display("FAIL lat0_hold got %h exp %h", douta0, 32'h1122_3344); end
    n_checks++; if (douta1 !== 32'h1122_3344) begin n_fail++; $display("FAIL lat1_douta got %h exp %h", douta1, 32'h1122_3344); end
    n_checks++; if (dvala1 !== 1'b1) begin n_fail++; $display("FAIL lat1_dvala got %b exp 1", dvala1); end
    cyc();
    n_checks++; if (dvala1 !== 1'b0) begin n_fail++; $display("FAIL lat1_dvala_pulse got %b exp 0", dvala1); end
  endtask

  task automatic test_byte_mask();
    wr_a(11'd7, 32'hAABB_CCDD, 4'hF);
    wr_a(11'd7, 32'h1122_3344, 4'b0101);
    ena = 1'b1; addra = 11'd7;
    cyc(); idle();
    n_checks++; if (douta0 !== 32'hAA22_CC44) begin n_fail++; $display("FAIL mask_douta0 got %h exp %h", douta0, 32'hAA22_CC44); end
    cyc();
    n_checks++; if (douta1 !== 32'hAA22_CC44) begin n_fail++; $display("FAIL mask_douta1 got %h exp %h", douta1, 32'hAA22_CC44); end
    cyc();
  endtask

  task automatic test_rdw_same();
    wr_a(11'd3, 32'h0, 4'hF);
    cyc();
    ena = 1'b1; wea = 4'hF; addra = 11'd3; dina = 32'hDEAD_BEEF;
    cyc();
    n_checks++; if (douta0 !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rdw_wf_douta got %h exp %h", douta0, 32'hDEAD_BEEF); end
    wea = 4'b0001; dina = 32'h0000_00AB;
    cyc(); idle();
    n_checks++; if (douta1 !== 32'h0) begin n_fail++; $display("FAIL rdw_rf_douta got %h exp %h", douta1, 32'h0); end
    n_checks++; if (douta0 !== 32'hDEAD_BEAB) begin n_fail++; $display("FAIL rdw_wf_merge got %h exp %h", douta0, 32'hDEAD_BEAB); end
    cyc();
    n_checks++; if (douta1 !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rdw_rf_old got %h exp %h", douta1, 32'hDEAD_BEEF); end
    cyc();
  endtask

  task automatic test_cross_port();
    enb = 1'b1; web = 4'hF; addrb = 11'd9; dinb = 32'h1234_5678;
    cyc(); idle(); cyc();
    ena = 1'b1; wea = 4'h0; addra = 11'd9;
    enb = 1'b1; web = 4'hF; addrb = 11'd9; dinb = 32'hCAFE_F00D;
    cyc(); idle();
    n_checks++; if (douta0 !== 32'h1234_5678) begin n_fail++; $display("FAIL xp_douta0 got %h exp %h", douta0, 32'h1234_5678); end
    n_checks++; if (doutb0 !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL xp_doutb0 got %h exp %h", doutb0, 32'hCAFE_F00D); end
    n_checks++; if (coll0 !== 1'b0) begin n_fail++; $display("FAIL xp_coll got %b exp 0", coll0); end
    cyc();
    n_checks++; if (douta1 !== 32'h1234_5678) begin n_fail++; $display("FAIL xp_douta1 got %h exp %h", douta1, 32'h1234_5678); end
    n_checks++; if (doutb1 !== 32'h1234_5678) begin n_fail++; $display("FAIL xp_doutb1 got %h exp %h", doutb1, 32'h1234_5678); end
    ena = 1'b1; addra = 11'd9;
    cyc(); idle();
    n_checks++; if (douta0 !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL xp_after got %h exp %h", douta0, 32'hCAFE_F00D); end
    cyc(); cyc();
  endtask

  task automatic test_collision();
    wr_a(11'h20, 32'h0, 4'hF);
    wr_a(11'h21, 32'hFFFF_FFFF, 4'hF);
    ena = 1'b1; wea = 4'b0011; addra = 11'h20; dina = 32'h0000_00AA;
    enb = 1'b1; web = 4'b0110; addrb = 11'h20; dinb = 32'h0000_BB00;
    cyc(); idle();
    n_checks++; if (coll0 !== 1'b1) begin n_fail++; $display("FAIL coll_pulse0 got %b exp 1", coll0); end
    n_checks++; if (coll1 !== 1'b1) begin n_fail++; $display("FAIL coll_pulse1 got %b exp 1", coll1); end
    cyc();
    n_checks++; if (coll0 !== 1'b0) begin n_fail++; $display("FAIL coll_one_cycle got %b exp 0", coll0); end
    ena = 1'b1; addra = 11'h20;
    cyc(); idle();
    n_checks++; if (douta0 !== 32'h0000_00AA) begin n_fail++; $display("FAIL coll_data got %h exp %h", douta0, 32'h0000_00AA); end
    ena = 1'b1; wea = 4'b0011; addra = 11'h21; dina = 32'h0000_00AA;
    enb = 1'b1; web = 4'b0110; addrb = 11'h21; dinb = 32'h00CC_BB00;
    cyc(); idle();
    ena = 1'b1; addra = 11'h21;
    cyc(); idle();
    n_checks++; if (douta0 !== 32'hFFCC_00AA) begin n_fail++; $display("FAIL coll_merge got %h exp %h", douta0, 32'hFFCC_00AA); end
    ena = 1'b1; wea = 4'b0011; addra = 11'h22; dina = 32'h0000_00AA;
    enb = 1'b1; web = 4'b0110; addrb = 11'h23; dinb = 32'h0000_BB00;
    cyc(); idle();
    n_checks++; if (coll0 !== 1'b0) begin n_fail++; $display("FAIL coll_diff_addr got %b exp 0", coll0); end
    ena = 1'b1; wea = 4'b0011; addra = 11'h24; dina = 32'h0;
    enb = 1'b1; web = 4'b1100; addrb = 11'h24; dinb = 32'h0;
    cyc(); idle();
    n_checks++; if (coll0 !== 1'b0) begin n_fail++; $display("FAIL coll_disjoint got %b exp 0", coll0); end
    cyc(); cyc();
  endtask

  task automatic test_reset_mid();
    ena = 1'b1; wea = 4'hF; addra = 11'h40; dina = 32'h0BAD_CAFE;
    cyc(); idle();
    n_checks++; if (dvala1 !== 1'b0) begin n_fail++; $display("FAIL mid_dvala_n got %b exp 0", dvala1); end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    n_checks++; if (dvala1 !== 1'b0) begin n_fail++; $display("FAIL mid_dvala_n1 got %b exp 0", dvala1); end
    cyc();
    n_checks++; if (dvala1 !== 1'b0) begin n_fail++; $display("FAIL mid_dvala_n2 got %b exp 0", dvala1); end
    cyc();
    n_checks++; if (dvala1 !== 1'b0) begin n_fail++; $display("FAIL mid_dvala_n3 got %b exp 0", dvala1); end
    n_checks++; if (douta1 !== 32'h0) begin n_fail++; $display("FAIL mid_douta got %h exp %h", douta1, 32'h0); end
    enb = 1'b1; addrb = 11'h40;
    cyc(); idle();
    n_checks++; if (doutb0 !== 32'h0BAD_CAFE) begin n_fail++; $display("FAIL mid_wr_persist got %h exp %h", doutb0, 32'h0BAD_CAFE); end
    cyc(); cyc();
  endtask

  task automatic test_back_to_back();
    ena = 1'b1; wea = 4'h0; addra = 11'd5;
    cyc();
    n_checks++; if (douta0 !== 32'h1122_3344 || dvala0 !== 1'b1) begin n_fail++; $display("FAIL b2b0_1 got %h/%b exp %h/1", douta0, dvala0, 32'h1122_3344); end
    addra = 11'd7;
    cyc();
    n_checks++; if (douta0 !== 32'hAA22_CC44 || dvala0 !== 1'b1) begin n_fail++; $display("FAIL b2b0_2 got %h/%b exp %h/1", douta0, dvala0, 32'hAA22_CC44); end
    n_checks++; if (douta1 !== 32'h1122_3344 || dvala1 !== 1'b1) begin n_fail++; $display("FAIL b2b1_1 got %h/%b exp %h/1", douta1, dvala1, 32'h1122_3344); end
    addra = 11'd9;
    cyc(); idle();
    n_checks++; if (douta0 !== 32'hCAFE_F00D || dvala0 !== 1'b1) begin n_fail++; $display("FAIL b2b0_3 got %h/%b exp %h/1", douta0, dvala0, 32'hCAFE_F00D); end
    n_checks++; if (douta1 !== 32'hAA22_CC44 || dvala1 !== 1'b1) begin n_fail++; $display("FAIL b2b1_2 got %h/%b exp %h/1", douta1, dvala1, 32'hAA22_CC44); end
    cyc();
    n_checks++; if (dvala0 !== 1'b0) begin n_fail++; $display("FAIL b2b0_end got %b exp 0", dvala0); end
    n_checks++; if (douta1 !== 32'hCAFE_F00D || dvala1 !== 1'b1) begin n_fail++; $display("FAIL b2b1_3 got %h/%b exp %h/1", douta1, dvala1, 32'hCAFE_F00D); end
    cyc();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_byte_mask();
    test_rdw_same();
    test_cross_port();
    test_collision();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
